merge_referee: RTL and testbench

MERGE_REFEREE -- requirements
Module: merge_referee

---
 rtl/merge_referee_pkg.sv | 28 ++
 rtl/merge_referee_rr_pick4.sv | 61 ++++++
 rtl/merge_referee.sv | 136 +++++++++++++
 tb/tb_merge_referee.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_referee_pkg.sv
// merge_referee_pkg -- shared transaction-layer definitions for the merge referee.
//
// Contents:
//   DATA_W        width of every FIFO word carried through the referee
//   NCH           number of source channels
//   LINK_*        encodings of the 4-bit link state input
//   fsm_e         arbiter FSM state encoding (IDLE / RUN / STALL)
//   link_active() true for either of the two active link encodings
package merge_referee_pkg;

  localparam int DATA_W = 12;
  localparam int NCH    = 4;

  localparam logic [3:0] LINK_RESET    = 4'b0001;
  localparam logic [3:0] LINK_ACTIVE_A = 4'b0100;
  localparam logic [3:0] LINK_ACTIVE_B = 4'b1000;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_RUN   = 2'd1,
    FSM_STALL = 2'd2
  } fsm_e;

  function automatic logic link_active(input logic [3:0] link_state);
    return (link_state == LINK_ACTIVE_A) || (link_state == LINK_ACTIVE_B);
  endfunction

endpackage

// File: rtl/merge_referee_rr_pick4.sv
// rr_pick4 -- channel eligibility and next-pointer logic for the merge referee.
//
// Purely combinational. A channel is eligible when its FIFO is not empty and
// it was not popped on the previous cycle (its head word is still the one
// being dequeued, so granting it again would duplicate that word).
//
// Build option: MERGE_REFEREE_SKIP_EMPTY_EN
//   defined   -> work-conserving: grant the first eligible channel at or
//                after ptr_i; pointer holds when nothing is eligible.
//   undefined -> strict TDM: only channel ptr_i may be granted; the pointer
//                advances every slot whether or not it was used.
//
// Ports:
//   ptr_i       current round-robin pointer
//   empty_i     source FIFO empty flags, bit n = channel n
//   last_pop_i  pop strobes registered on the previous cycle
//   grant_o     a channel is granted this slot
//   chan_o      granted channel (valid when grant_o)
//   ptr_next_o  pointer value to load when this slot is taken
module rr_pick4 (
  input  logic [1:0] ptr_i,
  input  logic [3:0] empty_i,
  input  logic [3:0] last_pop_i,
  output logic       grant_o,
  output logic [1:0] chan_o,
  output logic [1:0] ptr_next_o
);

  logic [3:0] eligible;

  assign eligible = ~empty_i & ~last_pop_i;

`ifdef MERGE_REFEREE_SKIP_EMPTY_EN
  logic [1:0] scan_idx;

  // Scan from the farthest offset down to ptr itself so the nearest
  // eligible channel is the last one written and therefore wins.
  always_comb begin
    grant_o  = 1'b0;
    chan_o   = ptr_i;
    scan_idx = ptr_i;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_i + 2'(k);
      if (eligible[scan_idx]) begin
        grant_o = 1'b1;
        chan_o  = scan_idx;
      end
    end
    ptr_next_o = grant_o ? (chan_o + 2'd1) : ptr_i;
  end
`else
  // In strict TDM the granted channel is always ptr, so n+1 and the idle
  // slot advance are the same value.
  always_comb begin
    grant_o    = eligible[ptr_i];
    chan_o     = ptr_i;
    ptr_next_o = ptr_i + 2'd1;
  end
`endif

endmodule

// File: rtl/merge_referee.sv
// merge_referee -- merges four source FIFOs into one destination FIFO.
//
// A three-state FSM (IDLE / RUN / STALL) follows the link state and the
// destination almost_full flag; in RUN a round-robin arbiter (rr_pick4)
// grants at most one source per cycle. All strobes and data_out are
// registered. Link state RESET clears everything synchronously; reset_L
// clears everything asynchronously.
//
// Build option: MERGE_REFEREE_SKIP_EMPTY_EN (see rr_pick4) selects
// work-conserving skipping of empty channels instead of strict TDM.
//
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   state[3:0]              link state (0001 reset, 0100/1000 active, else hold)
//   empty_0..3              source FIFO empty flags
//   data_in_0..3[11:0]      source FIFO head words
//   almost_full             destination FIFO almost-full flag
//   pop_0..3                registered dequeue strobes to the sources
//   push                    registered enqueue strobe to the destination
//   data_out[11:0]          registered word carried by push
module merge_referee
  import merge_referee_pkg::*;
(
  input  logic              clk,
  input  logic              reset_L,
  input  logic [3:0]        state,
  input  logic              empty_0,
  input  logic              empty_1,
  input  logic              empty_2,
  input  logic              empty_3,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic [DATA_W-1:0] data_in_2,
  input  logic [DATA_W-1:0] data_in_3,
  input  logic              almost_full,
  output logic              pop_0,
  output logic              pop_1,
  output logic              pop_2,
  output logic              pop_3,
  output logic              push,
  output logic [DATA_W-1:0] data_out
);

  fsm_e              fsm_q, fsm_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [NCH-1:0]    pop_q, pop_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [NCH-1:0]    empty_vec;
  logic [DATA_W-1:0] din [NCH];

  logic              pick_grant;
  logic [1:0]        pick_chan;
  logic [1:0]        pick_ptr_next;

  assign empty_vec = {empty_3, empty_2, empty_1, empty_0};
  assign din[0]    = data_in_0;
  assign din[1]    = data_in_1;
  assign din[2]    = data_in_2;
  assign din[3]    = data_in_3;

  // The registered pop vector doubles as the last-popped record: it is
  // exactly what was popped on the previous cycle and clears with reset.
  rr_pick4 u_pick (
    .ptr_i      (ptr_q),
    .empty_i    (empty_vec),
    .last_pop_i (pop_q),
    .grant_o    (pick_grant),
    .chan_o     (pick_chan),
    .ptr_next_o (pick_ptr_next)
  );

  always_comb begin
    fsm_d  = fsm_q;
    ptr_d  = ptr_q;
    pop_d  = '0;
    push_d = 1'b0;
    data_d = data_q;

    if (state == LINK_RESET) begin
      // Synchronous clear; any grant that would have been made is dropped.
      fsm_d  = FSM_IDLE;
      ptr_d  = 2'd0;
      data_d = '0;
    end else if (link_active(state)) begin
      case (fsm_q)
        FSM_IDLE: fsm_d = FSM_RUN;
        FSM_RUN: begin
          // almost_full wins over any candidate in the same cycle.
          if (almost_full) begin
            fsm_d = FSM_STALL;
          end else begin
            ptr_d = pick_ptr_next;
            if (pick_grant) begin
              pop_d[pick_chan] = 1'b1;
              push_d           = 1'b1;
              data_d           = din[pick_chan];
            end
          end
        end
        FSM_STALL: begin
          if (!almost_full) begin
            fsm_d = FSM_RUN;
          end
        end
        default: fsm_d = FSM_IDLE;
      endcase
    end
    // Any other link state: FSM, pointer and data hold, strobes drop.
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fsm_q  <= FSM_IDLE;
      ptr_q  <= 2'd0;
      pop_q  <= '0;
      push_q <= 1'b0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      ptr_q  <= ptr_d;
      pop_q  <= pop_d;
      push_q <= push_d;
      data_q <= data_d;
    end
  end

  assign pop_0    = pop_q[0];
  assign pop_1    = pop_q[1];
  assign pop_2    = pop_q[2];
  assign pop_3    = pop_q[3];
  assign push     = push_q;
  assign data_out = data_q;

endmodule

// File: tb/tb_merge_referee.sv
// tb_merge_referee -- scoreboard bench for merge_referee.
//
// Source FIFOs are modelled as small circular buffers that dequeue on the
// DUT's pop strobes. Each cycle the bench drives inputs on the falling edge,
// steps a reference model of the referee and queues the expected registered
// outputs; the next falling edge pops and compares them. Directed checks on
// the grant log cover the named streaming, stall, and reset scenarios.
// Works with and without MERGE_REFEREE_SKIP_EMPTY_EN.
`timescale 1ns/1ps
module tb_merge_referee;

  localparam logic [3:0] ST_RESET = 4'b0001;
  localparam logic [3:0] ST_A     = 4'b0100;
  localparam logic [3:0] ST_B     = 4'b1000;
  localparam logic [3:0] ST_HOLD  = 4'b0010;
  localparam int         DEPTH    = 16;
`ifdef MERGE_REFEREE_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_L;
  logic [3:0]  state;
  logic        empty_0, empty_1, empty_2, empty_3;
  logic [11:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic        almost_full;
  logic        pop_0, pop_1, pop_2, pop_3;
  logic        push;
  logic [11:0] data_out;
  logic [3:0]  pops;

  assign pops = {pop_3, pop_2, pop_1, pop_0};

  always #5 clk = ~clk;

  merge_referee dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .state       (state),
    .empty_0     (empty_0),
    .empty_1     (empty_1),
    .empty_2     (empty_2),
    .empty_3     (empty_3),
    .data_in_0   (data_in_0),
    .data_in_1   (data_in_1),
    .data_in_2   (data_in_2),
    .data_in_3   (data_in_3),
    .almost_full (almost_full),
    .pop_0       (pop_0),
    .pop_1       (pop_1),
    .pop_2       (pop_2),
    .pop_3       (pop_3),
    .push        (push),
    .data_out    (data_out)
  );

  typedef struct packed {
    logic [3:0]  pop;
    logic        push;
    logic [11:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] fifo_mem [4][DEPTH];
  int          fifo_head [4];
  int          fifo_cnt [4];
  int          wr_idx [4];
  logic        e_v [4];
  logic [11:0] d_v [4];

  // reference model state (0 = IDLE, 1 = RUN, 2 = STALL)
  int          m_fsm;
  int          m_ptr;
  logic [3:0]  m_pop;
  logic        m_push;
  logic [11:0] m_data;

  int          log_ch[$];
  int          log_cyc[$];
  logic [11:0] log_data[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        rst_req;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] word(input int c, input int i);
    return 12'((c + 1) * 256 + 160 + i);
  endfunction

  task automatic load(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      if (fifo_cnt[c] < DEPTH) begin
        fifo_mem[c][(fifo_head[c] + fifo_cnt[c]) % DEPTH] = word(c, wr_idx[c]);
        fifo_cnt[c]++;
        wr_idx[c]++;
      end
    end
  endtask

  task automatic drive_src();
    for (int c = 0; c < 4; c++) begin
      e_v[c] = (fifo_cnt[c] == 0);
      d_v[c] = e_v[c] ? 12'h000 : fifo_mem[c][fifo_head[c]];
    end
    empty_0 = e_v[0]; empty_1 = e_v[1]; empty_2 = e_v[2]; empty_3 = e_v[3];
    data_in_0 = d_v[0]; data_in_1 = d_v[1]; data_in_2 = d_v[2]; data_in_3 = d_v[3];
  endtask

  task automatic model_reset();
    m_fsm = 0; m_ptr = 0; m_pop = 4'b0; m_push = 1'b0; m_data = 12'h000;
  endtask

  // One rising edge of the reference model, using the inputs just driven.
  task automatic model_step();
    logic [3:0] prev;
    int g;
    if (!reset_L || state == ST_RESET) begin
      model_reset();
    end else if (state != ST_A && state != ST_B) begin
      m_pop = 4'b0; m_push = 1'b0;
    end else begin
      prev = m_pop; m_pop = 4'b0; m_push = 1'b0;
      if (m_fsm == 0) begin
        m_fsm = 1;
      end else if (m_fsm == 2) begin
        if (!almost_full) m_fsm = 1;
      end else if (almost_full) begin
        m_fsm = 2;
      end else begin
        g = -1;
        if (SKIP) begin
          for (int k = 0; k < 4 && g < 0; k++)
            if (!e_v[(m_ptr + k) % 4] && !prev[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end else if (!e_v[m_ptr] && !prev[m_ptr]) begin
          g = m_ptr;
        end
        if (g >= 0) begin
          m_pop[g] = 1'b1; m_push = 1'b1; m_data = d_v[g]; m_ptr = (g + 1) % 4;
        end else if (!SKIP) begin
          m_ptr = (m_ptr + 1) % 4;
        end
      end
    end
  endtask

  task automatic tick(input logic [3:0] st, input logic af);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("pop", 32'(pops), 32'(e.pop));
      check_val("push", 32'(push), 32'(e.push));
      check_val("data_out", 32'(data_out), 32'(e.data));
    end
    check_val("strobe_rule", 32'(($countones(pops) <= 1) && (push == (pops != 4'b0))), 32'd1);
    for (int c = 0; c < 4; c++) begin
      if (push && pops[c]) begin
        log_ch.push_back(c); log_cyc.push_back(cyc); log_data.push_back(data_out);
        $display("cycle %0d: grant ch%0d data 0x%03h", cyc, c, data_out);
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (pops[c] && fifo_cnt[c] > 0) begin
        fifo_head[c] = (fifo_head[c] + 1) % DEPTH;
        fifo_cnt[c]--;
      end
    end
    reset_L = rst_req; state = st; almost_full = af;
    drive_src();
    model_step();
    e.pop = m_pop; e.push = m_push; e.data = m_data;
    exp_q.push_back(e);
  endtask

  // Drops reset_L just after an edge that pushed, with no clock in between.
  task automatic async_reset_pulse();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("pre_rst_pop", 32'(pops), 32'(e.pop));
      check_val("pre_rst_data", 32'(data_out), 32'(e.data));
    end
    check_val("pre_rst_push", 32'(push), 32'd1);
    rst_req = 1'b0;
    reset_L = 1'b0;
    #1;
    check_val("arst_pops", 32'(pops), 32'd0);
    check_val("arst_push", 32'(push), 32'd0);
    check_val("arst_data", 32'(data_out), 32'd0);
    model_reset();
  endtask

  initial begin
    int base;
    int n;
    int n_pre;
    int left;

    rst_req = 1'b0; reset_L = 1'b1; state = ST_RESET; almost_full = 1'b0;
    for (int c = 0; c < 4; c++) begin
      fifo_head[c] = 0; fifo_cnt[c] = 0; wr_idx[c] = 0;
    end
    drive_src();
    model_reset();
    #1 reset_L = 1'b0;
    #1;
    check_val("rst_pops", 32'(pops), 32'd0);
    check_val("rst_push", 32'(push), 32'd0);
    check_val("rst_data", 32'(data_out), 32'd0);
    repeat (2) tick(ST_RESET, 1'b0);
    rst_req = 1'b1;
    repeat (2) tick(ST_RESET, 1'b0);

    // All four sources full: grants 0,1,2,3,0 back to back.
    for (int c = 0; c < 4; c++) load(c, 5);
    base = log_ch.size();
    repeat (8) tick(ST_A, 1'b0);
    check_val("s1_grant_count", 32'(log_ch.size() - base >= 5), 32'd1);
    if (log_ch.size() >= base + 5) begin
      for (int j = 0; j < 5; j++) begin
        check_val($sformatf("s1_ch_%0d", j), 32'(log_ch[base + j]), 32'(j % 4));
        check_val($sformatf("s1_data_%0d", j), 32'(log_data[base + j]), 32'(word(j % 4, j / 4)));
        check_val($sformatf("s1_cycle_%0d", j), 32'(log_cyc[base + j] - log_cyc[base]), 32'(j));
      end
    end
    repeat (20) tick(ST_A, 1'b0);
    left = fifo_cnt[0] + fifo_cnt[1] + fifo_cnt[2] + fifo_cnt[3];
    check_val("s1_drained", 32'(left), 32'd0);

    // Only source 2 holds three words.
    tick(ST_RESET, 1'b0);
    load(2, 3);
    base = log_ch.size();
    repeat (16) tick(ST_B, 1'b0);
    n = log_ch.size() - base;
    check_val("s2_push_count", 32'(n), 32'd3);
    if (n >= 3) begin
      for (int j = 0; j < 3; j++) begin
        check_val($sformatf("s2_ch_%0d", j), 32'(log_ch[base + j]), 32'd2);
        if (j > 0)
          check_val($sformatf("s2_gap_%0d", j), 32'(log_cyc[base + j] - log_cyc[base + j - 1]),
                    SKIP ? 32'd2 : 32'd4);
      end
    end

    // almost_full mid-stream, then a hold link state, then resume.
    for (int c = 0; c < 4; c++) load(c, 6);
    repeat (4) tick(ST_A, 1'b0);
    tick(ST_A, 1'b1);
    n_pre = log_ch.size();
    tick(ST_A, 1'b1);
    check_val("s3_stall_push", 32'(push), 32'd0);
    check_val("s3_stall_pops", 32'(pops), 32'd0);
    tick(ST_A, 1'b1);
    repeat (2) tick(ST_HOLD, 1'b0);
    repeat (6) tick(ST_A, 1'b0);
    check_val("s3_resumed", 32'(n_pre > 0 && log_ch.size() > n_pre), 32'd1);
    if (n_pre > 0 && log_ch.size() > n_pre)
      check_val("s3_resume_ch", 32'(log_ch[n_pre]), 32'((log_ch[n_pre - 1] + 1) % 4));

    // Asynchronous reset while pushing.
    for (int c = 0; c < 4; c++) load(c, 2);
    tick(ST_A, 1'b0);
    async_reset_pulse();
    repeat (2) tick(ST_A, 1'b0);
    rst_req = 1'b1;
    base = log_ch.size();
    repeat (5) tick(ST_A, 1'b0);
    check_val("s4_regranted", 32'(log_ch.size() > base), 32'd1);
    if (log_ch.size() > base) check_val("s4_first_ch", 32'(log_ch[base]), 32'd0);

    // One cycle of link RESET during RUN.
    for (int c = 0; c < 4; c++) load(c, 2);
    repeat (3) tick(ST_B, 1'b0);
    tick(ST_RESET, 1'b0);
    tick(ST_B, 1'b0);
    check_val("s5_pops", 32'(pops), 32'd0);
    check_val("s5_push", 32'(push), 32'd0);
    check_val("s5_data", 32'(data_out), 32'd0);
    base = log_ch.size();
    repeat (5) tick(ST_B, 1'b0);
    check_val("s5_regranted", 32'(log_ch.size() > base), 32'd1);
    if (log_ch.size() > base) check_val("s5_first_ch", 32'(log_ch[base]), 32'd0);

    tick(ST_B, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
